thread_scheduler: RTL and testbench
===================================

// Module: thread_scheduler
// PURPOSE
//   Selects which hardware thread (register file bank) issues each cycle in the barrel core.
//   Supersedes free-running thread rotation: round-robin over enabled, ready threads only.
//   Each thread gets a quantum; stalled threads are skipped or pre-empted.
//   Output tid drives register-file bank select and fetch PC select; sits between hazard unit and fetch.
// PARAMETERS
//   NUM_THREADS  4  number of hardware threads / register-file banks (power of 2, >=2)
//   TID_W        2  thread id width, = $clog2(NUM_THREADS)
//   QUANTUM      1  cycles a thread keeps the issue slot before rotating (>=1)
// PORTS
//   clk             in   1            core clock, all state on posedge
//   rst_n           in   1            asynchronous reset, active-low
//   thread_enable   in   NUM_THREADS  per-thread enable mask from CSR; 0 = never scheduled
//   thread_ready    in   NUM_THREADS  per-thread not-stalled (no pending load/branch hazard)
//   stall           in   1            global pipeline stall; freezes all scheduler state
//   issue_valid     out  1            issue_tid is a valid thread to fetch/issue this cycle
//   issue_tid       out  TID_W        thread owning the issue slot (bank select)
//   issue_switch    out  1            one-cycle pulse: issue_tid changed or issue_valid rose
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, issue_valid=0, issue_tid=0, issue_switch=0,
//     quantum cnt=0, rr pointer last=NUM_THREADS-1 (so first pick scans from thread 0).
//   eligible[i] = thread_enable[i] & thread_ready[i], sampled combinationally each cycle.
//   pick = first eligible index scanning last+1, last+2, ... wrapping mod NUM_THREADS,
//     last itself checked last. All outputs registered: inputs at cycle t -> outputs at t+1.
//   FSM (2 states):
//     IDLE: issue_valid=0. If !stall and |eligible: -> RUN, issue_tid<=pick, last<=pick,
//       cnt<=0, issue_switch<=1. Else stay, issue_tid holds.
//     RUN: issue_valid=1. Per non-stalled cycle:
//       - !eligible[issue_tid] (pre-empt): if |eligible -> switch to pick, cnt<=0;
//         else -> IDLE, issue_valid<=0.
//       - cnt==QUANTUM-1 (quantum expiry): switch to pick (may equal current tid if it is
//         the only eligible thread; then issue_switch<=0), cnt<=0.
//       - otherwise cnt<=cnt+1, tid holds.
//   Pre-emption has priority over quantum expiry; both resolve to same pick.
//   issue_switch<=1 only when new tid != previous issue_tid or IDLE->RUN; else 0.
//   stall=1: FSM, cnt, last, issue_tid, issue_valid hold; issue_switch forced 0.
//   thread_enable cleared for running thread: treated as pre-emption next edge.
//   cnt width $clog2(QUANTUM)+1; wraps only via explicit reset to 0, never overflows.
//   TID arithmetic mod NUM_THREADS: last=NUM_THREADS-1 wraps scan to 0.
//   rst_n asserted mid-operation: all outputs reset immediately (async), no partial state.
// TESTING
//   all enable=1111, ready=1111, QUANTUM=1 -> issue_tid 0,1,2,3,0,... every cycle, switch=1 each.
//   enable=0101, QUANTUM=2 -> tid 0,0,2,2,0,0; switch pulses only on first cycle of each pair.
//   ready[1] dropped while tid=1 mid-quantum (QUANTUM=4) -> next cycle tid=2, cnt restarts.
//   ready=0000 while RUN -> issue_valid=0 next cycle; ready[3]=1 -> valid=1, tid=3, switch=1.
//   stall=1 for 3 cycles at tid=2 -> tid=2, valid held, switch=0; resumes rotation after.
//   rst_n low for 1 cycle mid-rotation -> valid=0, tid=0 asynchronously; first pick thread 0.

Source files
------------

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - round-robin issue-slot scheduler for the barrel core
// Picks the next enabled, ready thread each quantum; registered issue_tid drives bank/PC select.
module thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS),
  parameter int QUANTUM     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic [NUM_THREADS-1:0] thread_ready,
  input  logic                   stall,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       issue_tid,
  output logic                   issue_switch
);

  localparam int CNT_W = $clog2(QUANTUM) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TID_W-1:0]   last, last_nxt;
  logic [TID_W-1:0]   tid_nxt;
  logic               valid_nxt, switch_nxt;

  logic [NUM_THREADS-1:0] eligible;
  logic                   any_eligible;
  logic [TID_W-1:0]       pick;
  logic [TID_W-1:0]       scan_idx;

  assign eligible     = thread_enable & thread_ready;
  assign any_eligible = |eligible;

  // Scan from farthest to nearest so the closest eligible thread after `last` wins;
  // `last` itself (k = NUM_THREADS wraps to offset 0) has the lowest priority.
  always_comb begin
    pick     = last;
    scan_idx = last;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      scan_idx = last + TID_W'(k);
      if (eligible[scan_idx]) pick = scan_idx;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    tid_nxt    = issue_tid;
    valid_nxt  = issue_valid;
    switch_nxt = 1'b0;

    if (!stall) begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state_nxt  = RUN;
            tid_nxt    = pick;
            last_nxt   = pick;
            cnt_nxt    = '0;
            valid_nxt  = 1'b1;
            switch_nxt = 1'b1;
          end
        end
        RUN: begin
          if (!eligible[issue_tid]) begin
            if (any_eligible) begin
              tid_nxt    = pick;
              last_nxt   = pick;
              cnt_nxt    = '0;
              switch_nxt = (pick != issue_tid);
            end else begin
              state_nxt = IDLE;
              valid_nxt = 1'b0;
              cnt_nxt   = '0;
            end
          end else if (cnt == CNT_LAST) begin
            tid_nxt    = pick;
            last_nxt   = pick;
            cnt_nxt    = '0;
            switch_nxt = (pick != issue_tid);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= TID_W'(NUM_THREADS - 1);
      issue_tid    <= '0;
      issue_valid  <= 1'b0;
      issue_switch <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      last         <= last_nxt;
      issue_tid    <= tid_nxt;
      issue_valid  <= valid_nxt;
      issue_switch <= switch_nxt;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - directed-vector bench for thread_scheduler
// Three instances (QUANTUM 1, 2, 4) share stimulus; each scenario checks the relevant one.
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] thread_enable = '0;
  logic [3:0] thread_ready = '0;
  logic       stall = 1'b0;

  logic       q1_valid, q1_switch;
  logic [1:0] q1_tid;
  logic       q2_valid, q2_switch;
  logic [1:0] q2_tid;
  logic       q4_valid, q4_switch;
  logic [1:0] q4_tid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  thread_scheduler #(.NUM_THREADS(4), .TID_W(2), .QUANTUM(1)) u_q1 (
    .clk(clk), .rst_n(rst_n), .thread_enable(thread_enable), .thread_ready(thread_ready),
    .stall(stall), .issue_valid(q1_valid), .issue_tid(q1_tid), .issue_switch(q1_switch));

  thread_scheduler #(.NUM_THREADS(4), .TID_W(2), .QUANTUM(2)) u_q2 (
    .clk(clk), .rst_n(rst_n), .thread_enable(thread_enable), .thread_ready(thread_ready),
    .stall(stall), .issue_valid(q2_valid), .issue_tid(q2_tid), .issue_switch(q2_switch));

  thread_scheduler #(.NUM_THREADS(4), .TID_W(2), .QUANTUM(4)) u_q4 (
    .clk(clk), .rst_n(rst_n), .thread_enable(thread_enable), .thread_ready(thread_ready),
    .stall(stall), .issue_valid(q4_valid), .issue_tid(q4_tid), .issue_switch(q4_switch));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q1(input string tag, input int v, input int t, input int s);
    chk({tag, ".valid"}, int'(q1_valid), v);
    chk({tag, ".tid"}, int'(q1_tid), t);
    chk({tag, ".switch"}, int'(q1_switch), s);
  endtask

  task automatic expect_q2(input string tag, input int v, input int t, input int s);
    chk({tag, ".valid"}, int'(q2_valid), v);
    chk({tag, ".tid"}, int'(q2_tid), t);
    chk({tag, ".switch"}, int'(q2_switch), s);
  endtask

  task automatic expect_q4(input string tag, input int v, input int t, input int s);
    chk({tag, ".valid"}, int'(q4_valid), v);
    chk({tag, ".tid"}, int'(q4_tid), t);
    chk({tag, ".switch"}, int'(q4_switch), s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    thread_enable = '0;
    thread_ready = '0;
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int rot_tid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int q2_tids[6] = '{0, 0, 2, 2, 0, 0};
    int q2_sw[6]   = '{1, 0, 1, 0, 1, 0};

    // Reset state for all quanta
    do_reset();
    expect_q1("rst_q1", 0, 0, 0);
    expect_q2("rst_q2", 0, 0, 0);
    expect_q4("rst_q4", 0, 0, 0);

    // Full rotation, QUANTUM=1
    thread_enable = 4'b1111;
    thread_ready  = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_q1($sformatf("rot%0d", i), 1, rot_tid[i], 1);
    end

    // Sparse enable, QUANTUM=2
    do_reset();
    thread_enable = 4'b0101;
    thread_ready  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_q2($sformatf("sparse%0d", i), 1, q2_tids[i], q2_sw[i]);
    end

    // Pre-emption mid-quantum, QUANTUM=4
    do_reset();
    thread_enable = 4'b1111;
    thread_ready  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_q4($sformatf("q4_t0_%0d", i), 1, 0, (i == 0) ? 1 : 0);
    end
    tick();
    expect_q4("q4_t1_0", 1, 1, 1);
    tick();
    expect_q4("q4_t1_1", 1, 1, 0);
    thread_ready = 4'b1101;
    tick();
    expect_q4("preempt", 1, 2, 1);
    thread_ready = 4'b1111;
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_q4($sformatf("q4_t2_%0d", i), 1, 2, 0);
    end
    tick();
    expect_q4("q4_t3_0", 1, 3, 1);

    // All threads stalled, then only thread 3 ready, QUANTUM=1
    do_reset();
    thread_enable = 4'b1111;
    thread_ready  = 4'b1111;
    tick();
    expect_q1("idle_pre", 1, 0, 1);
    thread_ready = 4'b0000;
    tick();
    expect_q1("idle_drop", 0, 0, 0);
    tick();
    expect_q1("idle_hold", 0, 0, 0);
    thread_ready = 4'b1000;
    tick();
    expect_q1("idle_wake", 1, 3, 1);

    // Global stall freezes the slot at thread 2
    thread_ready = 4'b1111;
    tick();
    expect_q1("pre_stall0", 1, 0, 1);
    tick();
    expect_q1("pre_stall1", 1, 1, 1);
    tick();
    expect_q1("pre_stall2", 1, 2, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_q1($sformatf("stall%0d", i), 1, 2, 0);
    end
    stall = 1'b0;
    tick();
    expect_q1("resume0", 1, 3, 1);
    tick();
    expect_q1("resume1", 1, 0, 1);
    tick();
    expect_q1("resume2", 1, 1, 1);

    // Asynchronous reset mid-rotation
    rst_n = 1'b0;
    #2;
    expect_q1("async_rst", 0, 0, 0);
    expect_q4("async_rst_q4", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_q1("rst_held", 0, 0, 0);
    tick();
    expect_q1("post_rst0", 1, 0, 1);
    tick();
    expect_q1("post_rst1", 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
